// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame controller.
// Frame layout: SYNC, ADDR, LEN, LEN payload bytes, XOR checksum.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        LEN,
        DATA,
        CHK,
        WRITE
    } state_t;

    localparam logic [1:0] ERR_PARITY  = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_timeout.sv
// Loadable down-counter that pulses expire on the last cycle of a TIMEOUT_CLKS window.
// A load restarts the window; clear parks the counter at zero until the next load.
module uart_rx_timeout #(
    parameter int TIMEOUT_CLKS = 12000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    logic [TW-1:0] count;

    // Loaded with TIMEOUT_CLKS-1 so that expire lands on the cycle whose edge is the TIMEOUT_CLKS-th after the load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= TW'(TIMEOUT_CLKS - 1);
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expire = enable && !load && (count == TW'(1));

endmodule

// File: rtl/uart_frame_ctrl.sv
// Sequences received UART bytes into command frames, validates them and replays
// the payload as register write strobes; errors abort the frame and are counted.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         CLK_FREQ     = 6000000,
    parameter int         TIMEOUT_CLKS = 12000,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_parity_error,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int               IDX_W     = $clog2(MAX_LEN + 1);
    localparam int               BUF_DEPTH = 1 << IDX_W;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    if (MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_CLKS < 2 || CLK_FREQ < 1) begin : g_param_check
        $error("uart_frame_ctrl: unsupported parameter combination");
    end

    state_t           state;
    logic             rx_prev;
    logic             byte_event;
    logic [7:0]       frame_addr;
    logic [7:0]       checksum;
    logic [IDX_W-1:0] frame_len;
    logic [IDX_W-1:0] index;
    logic [7:0]       buffer [BUF_DEPTH];
    logic             timer_enable;
    logic             expire;
    logic             len_bad;
    logic             err_hit;
    logic [1:0]       err_cause;

    assign byte_event   = rx_done && !rx_prev;
    assign timer_enable = state inside {ADDR, LEN, DATA, CHK};
    assign busy         = (state != HUNT);
    assign len_bad      = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);

    uart_rx_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .load  (byte_event),
        .clear (!timer_enable),
        .enable(timer_enable),
        .expire(expire)
    );

    // A byte event always beats a simultaneous timeout, and parity beats any content check.
    always_comb begin
        err_hit   = 1'b0;
        err_cause = ERR_PARITY;
        if (timer_enable) begin
            if (byte_event) begin
                if (rx_parity_error) begin
                    err_hit   = 1'b1;
                    err_cause = ERR_PARITY;
                end else if (state == LEN && len_bad) begin
                    err_hit   = 1'b1;
                    err_cause = ERR_LEN;
                end else if (state == CHK && rx_data != checksum) begin
                    err_hit   = 1'b1;
                    err_cause = ERR_CHK;
                end
            end else if (expire) begin
                err_hit   = 1'b1;
                err_cause = ERR_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && byte_event && !rx_parity_error) begin
            buffer[index] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            rx_prev    <= 1'b0;
            frame_addr <= '0;
            frame_len  <= '0;
            index      <= '0;
            checksum   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
            err_count  <= '0;
        end else begin
            rx_prev   <= rx_done;
            wr_en     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (err_hit) begin
                frame_err <= 1'b1;
                err_code  <= err_cause;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                state <= HUNT;
            end else begin
                case (state)
                    HUNT: begin
                        if (byte_event && !rx_parity_error && rx_data == SYNC_BYTE) begin
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (byte_event) begin
                            frame_addr <= rx_data;
                            checksum   <= rx_data;
                            state      <= LEN;
                        end
                    end
                    LEN: begin
                        if (byte_event) begin
                            frame_len <= rx_data[IDX_W-1:0];
                            checksum  <= checksum ^ rx_data;
                            index     <= '0;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (byte_event) begin
                            checksum <= checksum ^ rx_data;
                            index    <= index + IDX_ONE;
                            if (index + IDX_ONE == frame_len) begin
                                state <= CHK;
                            end
                        end
                    end
                    // The first strobe is issued straight from the checksum byte so it appears one cycle later.
                    CHK: begin
                        if (byte_event) begin
                            wr_en   <= 1'b1;
                            wr_addr <= frame_addr;
                            wr_data <= buffer[0];
                            index   <= IDX_ONE;
                            if (frame_len == IDX_ONE) begin
                                frame_ok <= 1'b1;
                                state    <= HUNT;
                            end else begin
                                state <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        wr_en   <= 1'b1;
                        wr_addr <= frame_addr + 8'(index);
                        wr_data <= buffer[index];
                        index   <= index + IDX_ONE;
                        if (index + IDX_ONE == frame_len) begin
                            frame_ok <= 1'b1;
                            state    <= HUNT;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomised and directed bench for uart_frame_ctrl against a frame-level reference model.
// The model parses the recorded byte stream directly from the frame rules.
module tb_uart_frame_ctrl;

    localparam int         TO      = 12000;
    localparam int         MAX_LEN = 4;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_error;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic       busy;

    uart_frame_ctrl #(
        .CLK_FREQ    (6000000),
        .TIMEOUT_CLKS(TO),
        .SYNC_BYTE   (SYNC),
        .MAX_LEN     (MAX_LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_done        (rx_done),
        .rx_parity_error(rx_parity_error),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .err_code       (err_code),
        .err_count      (err_count),
        .busy           (busy)
    );

    int check_count = 0;
    int error_count = 0;
    int cyc = 0;
    int evt_cyc = 0;

    logic [7:0]  sb[$];
    bit          sp[$];
    logic [15:0] exp_wr[$];
    logic [1:0]  exp_err[$];
    int          exp_ok = 0;
    int          model_err_count = 0;
    logic [1:0]  last_code = 2'd0;
    bit          has_err = 0;

    logic [15:0] obs_wr[$];
    int          obs_wr_cyc[$];
    logic [1:0]  obs_err[$];
    int          obs_err_cyc[$];
    int          obs_ok = 0;
    int          obs_ok_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                obs_wr.push_back({wr_addr, wr_data});
                obs_wr_cyc.push_back(cyc);
            end
            if (frame_ok) begin
                obs_ok++;
                obs_ok_cyc = cyc;
            end
            if (frame_err) begin
                obs_err.push_back(err_code);
                obs_err_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit par, input int hold, input int gap);
        @(posedge clk);
        #1;
        rx_data         = data;
        rx_parity_error = par;
        rx_done         = 1'b1;
        evt_cyc         = cyc;
        sb.push_back(data);
        sp.push_back(par);
        @(posedge clk);
        #1;
        rx_data = 8'($urandom);
        repeat (hold - 1) @(posedge clk);
        #1;
        rx_done         = 1'b0;
        rx_parity_error = 1'($urandom);
        repeat (gap) @(posedge clk);
    endtask

    task automatic sendByte(input logic [7:0] data, input bit par = 0);
        applyStimulus(data, par, $urandom_range(1, 3), $urandom_range(4, 7));
    endtask

    task automatic modelError(input logic [1:0] code);
        exp_err.push_back(code);
        if (model_err_count < 255) model_err_count++;
        last_code = code;
        has_err   = 1;
    endtask

    // Frame-level parse of everything sent since the last scenario.
    task automatic runModel();
        int i = 0;
        int n = sb.size();
        int l;
        logic [7:0] a;
        logic [7:0] x;
        logic [7:0] pay[$];
        bit aborted;
        while (i < n) begin
            if (sb[i] != SYNC || sp[i]) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            if (sp[i]) begin modelError(2'd0); i++; continue; end
            a = sb[i];
            i++;
            if (i >= n) break;
            if (sp[i]) begin modelError(2'd0); i++; continue; end
            l = int'(sb[i]);
            i++;
            if (l == 0 || l > MAX_LEN) begin modelError(2'd1); continue; end
            pay.delete();
            aborted = 0;
            while (pay.size() < l && i < n && !aborted) begin
                if (sp[i]) begin
                    modelError(2'd0);
                    aborted = 1;
                end else begin
                    pay.push_back(sb[i]);
                end
                i++;
            end
            if (aborted || i >= n) continue;
            if (sp[i]) begin modelError(2'd0); i++; continue; end
            x = a ^ 8'(l);
            foreach (pay[k]) x = x ^ pay[k];
            if (sb[i] != x) begin
                modelError(2'd2);
            end else begin
                foreach (pay[k]) exp_wr.push_back({a + 8'(k), pay[k]});
                exp_ok++;
            end
            i++;
        end
    endtask

    task automatic clearAll();
        sb.delete(); sp.delete();
        exp_wr.delete(); exp_err.delete(); exp_ok = 0;
        obs_wr.delete(); obs_wr_cyc.delete(); obs_err.delete(); obs_err_cyc.delete(); obs_ok = 0;
    endtask

    task automatic finishScenario(input string tag);
        repeat (10) @(posedge clk);
        runModel();
        checkOutput($sformatf("%s wr_count", tag), obs_wr.size(), exp_wr.size());
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
            checkOutput($sformatf("%s wr[%0d]", tag, i), obs_wr[i], exp_wr[i]);
        checkOutput($sformatf("%s err_pulses", tag), obs_err.size(), exp_err.size());
        for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
            checkOutput($sformatf("%s err_code[%0d]", tag, i), obs_err[i], exp_err[i]);
        checkOutput($sformatf("%s frame_ok_count", tag), obs_ok, exp_ok);
        checkOutput($sformatf("%s err_count", tag), err_count, model_err_count);
        if (has_err) checkOutput($sformatf("%s err_code_held", tag), err_code, last_code);
        checkOutput($sformatf("%s busy_idle", tag), busy, 1'b0);
        clearAll();
    endtask

    task automatic sendRandomFrame(input int kind);
        logic [7:0] a = 8'($urandom);
        int         l = $urandom_range(1, MAX_LEN);
        logic [7:0] x;
        int         ppos = $urandom_range(0, l + 2);
        if (kind == 2) begin
            sendByte(SYNC);
            sendByte(a);
            sendByte(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
            return;
        end
        sendByte(SYNC);
        // Byte positions after SYNC: 0 addr, 1 len, 2..l+1 payload, l+2 checksum.
        if (kind == 3 && ppos == 0) begin sendByte(a, 1); return; end
        sendByte(a);
        if (kind == 3 && ppos == 1) begin sendByte(8'(l), 1); return; end
        sendByte(8'(l));
        x = a ^ 8'(l);
        for (int k = 0; k < l; k++) begin
            logic [7:0] d = 8'($urandom);
            x = x ^ d;
            if (kind == 3 && ppos == k + 2) begin sendByte(d, 1); return; end
            sendByte(d);
        end
        if (kind == 1) x = x ^ 8'(1 << $urandom_range(0, 7));
        sendByte(x, (kind == 3));
    endtask

    initial begin
        reset           = 1'b1;
        rx_data         = 8'd0;
        rx_done         = 1'b0;
        rx_parity_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset wr_en", wr_en, 1'b0);
        checkOutput("reset outputs", {wr_addr, wr_data, frame_ok, frame_err, err_code, err_count, busy}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Test 1: good frame with strobe timing.
        sendByte(SYNC);
        @(negedge clk);
        checkOutput("t1 busy_after_sync", busy, 1'b1);
        sendByte(8'h10); sendByte(8'h02); sendByte(8'h11); sendByte(8'h22);
        applyStimulus(8'h21, 0, 1, 10);
        checkOutput("t1 strobes", obs_wr.size(), 2);
        if (obs_wr.size() >= 2) begin
            checkOutput("t1 first_strobe_cycle", obs_wr_cyc[0], evt_cyc + 1);
            checkOutput("t1 second_strobe_cycle", obs_wr_cyc[1], evt_cyc + 2);
            checkOutput("t1 frame_ok_cycle", obs_ok_cyc, evt_cyc + 2);
            checkOutput("t1 write0", obs_wr[0], 16'h1011);
            checkOutput("t1 write1", obs_wr[1], 16'h1122);
        end
        finishScenario("t1");

        // Test 2: bad checksum, then the good frame again.
        sendByte(SYNC); sendByte(8'h10); sendByte(8'h02); sendByte(8'h11); sendByte(8'h22); sendByte(8'h20);
        repeat (4) @(posedge clk);
        checkOutput("t2 err_code", err_code, 2'd2);
        checkOutput("t2 err_count", err_count, 8'd1);
        sendByte(SYNC); sendByte(8'h10); sendByte(8'h02); sendByte(8'h11); sendByte(8'h22); sendByte(8'h21);
        finishScenario("t2");

        // Test 3: noise, then zero and oversize lengths.
        sendByte(8'h00); sendByte(8'hFF); sendByte(8'h3C);
        sendByte(SYNC); sendByte(8'h10); sendByte(8'h00);
        sendByte(SYNC); sendByte(8'h10); sendByte(8'h05);
        finishScenario("t3");

        // Test 4a: timeout exactly TO cycles after the last byte event.
        sendByte(SYNC);
        applyStimulus(8'h10, 0, 1, 0);
        while (obs_err.size() == 0 && cyc < evt_cyc + TO + 50) @(posedge clk);
        checkOutput("t4 timeout_seen", obs_err.size(), 1);
        if (obs_err.size() >= 1) begin
            checkOutput("t4 timeout_cycle", obs_err_cyc[0], evt_cyc + TO);
            checkOutput("t4 timeout_code", obs_err[0], 2'd3);
        end
        if (model_err_count < 255) model_err_count++;
        last_code = 2'd3;
        has_err   = 1;
        repeat (2) @(posedge clk);
        checkOutput("t4 err_count", err_count, model_err_count);
        checkOutput("t4 busy_after_timeout", busy, 1'b0);
        clearAll();

        // Test 4b: a byte event on the last cycle of the window keeps the frame alive.
        sendByte(SYNC);
        applyStimulus(8'h10, 0, 1, 0);
        begin
            int target = evt_cyc + TO - 1;
            while (cyc < target - 1) begin @(posedge clk); #1; end
        end
        applyStimulus(8'h01, 0, 1, 5);
        sendByte(8'h33);
        sendByte(8'h10 ^ 8'h01 ^ 8'h33);
        finishScenario("t4b");

        // Test 5: parity on a payload byte, then SYNC with parity in HUNT.
        sendByte(SYNC); sendByte(8'h10); sendByte(8'h02); sendByte(8'h11, 1);
        sendByte(SYNC, 1);
        finishScenario("t5");

        // Test 6: address wrap FF -> 00.
        sendByte(SYNC); sendByte(8'hFF); sendByte(8'h02); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hEC);
        repeat (10) @(posedge clk);
        if (obs_wr.size() >= 2) checkOutput("t6 wrap_write", obs_wr[1], 16'h00BB);
        finishScenario("t6");

        // Reset mid-frame.
        sendByte(SYNC); sendByte(8'h10); sendByte(8'h02); sendByte(8'h11);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst busy", busy, 1'b0);
        checkOutput("rst err_count", err_count, 8'd0);
        checkOutput("rst err_code", err_code, 2'd0);
        checkOutput("rst strobes", {wr_en, frame_ok, frame_err}, 3'b000);
        checkOutput("rst wr_bus", {wr_addr, wr_data}, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_err_count = 0;
        has_err         = 0;
        clearAll();
        sendByte(SYNC); sendByte(8'h40); sendByte(8'h01); sendByte(8'h5A); sendByte(8'h40 ^ 8'h01 ^ 8'h5A);
        finishScenario("t6rst");

        // Randomised frames of every kind interleaved with noise.
        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(0, 4);
            if (kind == 4) begin
                logic [7:0] nb = 8'($urandom);
                sendByte(nb, (nb == SYNC));
            end else begin
                sendRandomFrame(kind);
            end
            finishScenario($sformatf("rand%0d", it));
        end

        // Saturation of the error counter.
        for (int it = 0; it < 260; it++) begin
            applyStimulus(SYNC, 0, 1, 1);
            applyStimulus(8'h10, 0, 1, 1);
            applyStimulus(8'h00, 0, 1, 1);
        end
        finishScenario("sat");
        checkOutput("sat err_count_max", err_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
